// File: rtl/ksa_add_arbiter_if.sv
// Requester and response bundle for the shared-adder arbiter.
// The arbiter is the slave side; the requester/consumer cluster is the master.
interface ksa_add_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       req_last;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_last;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last
    );
endinterface

// File: rtl/ksa_add_arbiter.sv
// Round-robin sequencer sharing one combinational adder among NREQ requesters.
// Two register stages (OP, RSP); bursts chain carry-out into the next beat.
module ksa_add_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    ksa_add_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]  add_a,
    output logic [WIDTH-1:0]  add_b,
    output logic              add_cin,
    input  logic [WIDTH-1:0]  add_sum,
    input  logic              add_cout
);
    typedef enum logic {IDLE, LOCK} arb_state_e;

    arb_state_e state, state_nxt;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   lock_id;
    logic [IDW-1:0]   rr_idx;
    logic [IDW-1:0]   rr_gnt;
    logic             rr_hit;
    logic [IDW-1:0]   grant;
    logic             grant_vld;

    logic             op_vld;
    logic [IDW-1:0]   op_id;
    logic             op_last;
    logic             carry_reg;

    logic             rsp_adv;
    logic             op_adv;
    logic             can_accept;
    logic             xfer;
    logic             cin_sel;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
    end

    assign rsp_adv    = !bus.rsp_valid || bus.rsp_ready;
    assign op_adv     = op_vld && rsp_adv;
    assign can_accept = !op_vld || rsp_adv;

    // First valid requester after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        rr_gnt = '0;
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!rr_hit && bus.req_valid[rr_idx]) begin
                rr_hit = 1'b1;
                rr_gnt = rr_idx;
            end
        end
    end

    always_comb begin
        grant     = rr_gnt;
        grant_vld = rr_hit;
        cin_sel   = bus.req_cin[rr_gnt];
        unique case (state)
            IDLE: begin
                grant     = rr_gnt;
                grant_vld = rr_hit;
                cin_sel   = bus.req_cin[rr_gnt];
            end
            LOCK: begin
                grant     = lock_id;
                grant_vld = 1'b1;
                // Previous beat still in OP means its carry is only live.
                cin_sel   = op_vld ? add_cout : carry_reg;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (can_accept && grant_vld && !rst)
            bus.req_ready[grant] = 1'b1;
    end

    assign xfer = |(bus.req_valid & bus.req_ready);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (xfer && !bus.req_last[grant]) state_nxt = LOCK;
            LOCK: if (xfer &&  bus.req_last[grant]) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= IDW'(NREQ - 1);
            lock_id <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                rr_ptr  <= grant;
                lock_id <= grant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_vld    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            op_id     <= '0;
            op_last   <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            if (xfer) begin
                op_vld  <= 1'b1;
                add_a   <= a_arr[grant];
                add_b   <= b_arr[grant];
                add_cin <= cin_sel;
                op_id   <= grant;
                op_last <= bus.req_last[grant];
            end else if (rsp_adv) begin
                op_vld <= 1'b0;
            end
            if (op_adv)
                carry_reg <= add_cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_last  <= 1'b0;
        end else if (op_adv) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_sum   <= add_sum;
            bus.rsp_cout  <= add_cout;
            bus.rsp_id    <= op_id;
            bus.rsp_last  <= op_last;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ksa_add_arbiter.sv
// Bench for ksa_add_arbiter: queue-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then a randomized burst mix.
module tb_ksa_add_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         last;
        int           gap;
    } beat_t;

    typedef struct {
        logic [W-1:0] sum;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         cout;
        logic         last;
        logic         in_rsp;
        int           id;
    } exp_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         last;
        int           id;
        int           cyc;
    } log_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ksa_add_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);

    ksa_add_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    beat_t bq [N][$];
    exp_t  pend[$];
    log_t  rlog[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int rr_m, lock_m;
    bit locked_m;
    bit in_burst [N];
    bit carry_m  [N];

    bit pres     [N];
    int gap_left [N];
    int acc_cnt  [N];
    int rdy_mode = 0;
    int rdy_pct  = 70;
    bit prev_rst = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int i, logic [W-1:0] a, logic [W-1:0] b,
                        logic cin, logic last, int gap);
        beat_t x;
        x.a = a; x.b = b; x.cin = cin; x.last = last; x.gap = gap;
        bq[i].push_back(x);
    endtask

    function automatic bit idle();
        bit r = (pend.size() == 0);
        for (int i = 0; i < N; i++)
            if (bq[i].size() != 0 || pres[i]) r = 0;
        return r;
    endfunction

    task automatic model_reset();
        pend.delete();
        rr_m = N - 1;
        lock_m = 0;
        locked_m = 0;
        for (int i = 0; i < N; i++) begin
            in_burst[i] = 0;
            carry_m[i]  = 0;
            bq[i].delete();
            pres[i]     = 0;
            gap_left[i] = -1;
        end
    endtask

    // Checker, model and driver: compare at negedge, advance 1 after posedge.
    logic [N-1:0] ex_ready, ex_x, dut_x;
    bit           ex_rv, ex_fire, dut_fire;

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            ex_x = '0;
            ex_fire = 0;
            ex_rv = 0;
            if (rst) begin
                if (!prev_rst) model_reset();
                prev_rst = 1;
                chk("rst_req_ready", 32'(bus.req_ready), 0);
                chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
                chk("rst_add_regs", 32'({add_a, add_b, add_cin}), 0);
            end else begin
                int n, g;
                bit gv, can_acc;
                prev_rst = 0;
                n = pend.size();
                can_acc = (n < 2) || bus.rsp_ready;
                gv = 0;
                g = 0;
                if (locked_m) begin
                    gv = 1;
                    g = lock_m;
                end else begin
                    for (int k = 1; k <= N; k++)
                        if (!gv && bus.req_valid[(rr_m + k) % N]) begin
                            gv = 1;
                            g = (rr_m + k) % N;
                        end
                end
                ex_ready = (can_acc && gv) ? N'(1 << g) : '0;
                ex_rv = (n > 0) && pend[0].in_rsp;
                chk("req_ready", 32'(bus.req_ready), 32'(ex_ready));
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(ex_rv));
                if (ex_rv) begin
                    chk("rsp_sum", 32'(bus.rsp_sum), 32'(pend[0].sum));
                    chk("rsp_cout", 32'(bus.rsp_cout), 32'(pend[0].cout));
                    chk("rsp_id", 32'(bus.rsp_id), 32'(pend[0].id));
                    chk("rsp_last", 32'(bus.rsp_last), 32'(pend[0].last));
                end
                if (n > 0 && !pend[n-1].in_rsp) begin
                    chk("add_a", 32'(add_a), 32'(pend[n-1].a));
                    chk("add_b", 32'(add_b), 32'(pend[n-1].b));
                    chk("add_cin", 32'(add_cin), 32'(pend[n-1].cin));
                end
                ex_x = ex_ready & bus.req_valid;
                ex_fire = ex_rv && bus.rsp_ready;
            end
            dut_x = bus.req_valid & bus.req_ready;
            dut_fire = bus.rsp_valid && bus.rsp_ready;
            if (dut_fire) begin
                log_t l;
                l.sum = bus.rsp_sum; l.cout = bus.rsp_cout;
                l.last = bus.rsp_last; l.id = int'(bus.rsp_id); l.cyc = cyc;
                rlog.push_back(l);
            end

            @(posedge clk);
            #1;
            if (!rst) begin
                int n0;
                bit op_present, rsp_free;
                n0 = pend.size();
                op_present = (n0 > 0) && !pend[n0-1].in_rsp;
                rsp_free = !ex_rv || bus.rsp_ready;
                if (ex_fire) void'(pend.pop_front());
                if (op_present && rsp_free) begin
                    exp_t e;
                    e = pend[pend.size()-1];
                    e.in_rsp = 1;
                    pend[pend.size()-1] = e;
                end
                for (int i = 0; i < N; i++) if (ex_x[i]) begin
                    exp_t e;
                    logic [W:0] s;
                    e.a = bus.req_a[i*W +: W];
                    e.b = bus.req_b[i*W +: W];
                    e.cin = in_burst[i] ? carry_m[i] : bus.req_cin[i];
                    s = {1'b0, e.a} + {1'b0, e.b} + (W+1)'(e.cin);
                    e.sum = s[W-1:0];
                    e.cout = s[W];
                    e.last = bus.req_last[i];
                    e.id = i;
                    e.in_rsp = 0;
                    pend.push_back(e);
                    carry_m[i] = s[W];
                    in_burst[i] = !e.last;
                    rr_m = i;
                    locked_m = !e.last;
                    lock_m = i;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (dut_x[i]) begin
                    if (bq[i].size() > 0) void'(bq[i].pop_front());
                    pres[i] = 0;
                    acc_cnt[i]++;
                end
                if (!pres[i] && bq[i].size() > 0) begin
                    if (gap_left[i] < 0) gap_left[i] = bq[i][0].gap;
                    if (gap_left[i] == 0) begin
                        pres[i] = 1;
                        gap_left[i] = -1;
                    end else begin
                        gap_left[i]--;
                    end
                end
                bus.req_valid[i] = pres[i];
                if (pres[i]) begin
                    bus.req_a[i*W +: W] = bq[i][0].a;
                    bus.req_b[i*W +: W] = bq[i][0].b;
                    bus.req_cin[i]      = bq[i][0].cin;
                    bus.req_last[i]     = bq[i][0].last;
                end else begin
                    bus.req_a[i*W +: W] = W'($urandom);
                    bus.req_b[i*W +: W] = W'($urandom);
                    bus.req_cin[i]      = 1'($urandom);
                    bus.req_last[i]     = 1'($urandom);
                end
            end
            case (rdy_mode)
                0: bus.rsp_ready = 1'b1;
                1: bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = ($urandom_range(0, 99) < rdy_pct);
            endcase
        end
    end

    task automatic wait_idle(int bound);
        int k = 0;
        while (!idle() && k < bound) begin
            @(posedge clk);
            k++;
        end
        #2;
        total++;
        if (!idle()) begin
            bad++;
            $display("FAIL idle_timeout: pending=%0d after %0d cycles", pend.size(), bound);
        end
    endtask

    task automatic do_reset(int cycles);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic chk_log(int k, logic [W-1:0] sum, logic cout, int id, logic last);
        if (k >= rlog.size()) begin
            chk($sformatf("log%0d_present", k), 32'(rlog.size()), 32'(k + 1));
        end else begin
            chk($sformatf("log%0d_sum", k), 32'(rlog[k].sum), 32'(sum));
            chk($sformatf("log%0d_cout", k), 32'(rlog[k].cout), 32'(cout));
            chk($sformatf("log%0d_id", k), 32'(rlog[k].id), 32'(id));
            chk($sformatf("log%0d_last", k), 32'(rlog[k].last), 32'(last));
        end
    endtask

    initial begin
        int acc0, nbeats, k;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_cin = '0;
        bus.req_last = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        rlog.delete();
        push(0, 8'h3C, 8'h5A, 1'b0, 1'b1, 0);
        wait_idle(50);
        chk("single_count", 32'(rlog.size()), 1);
        chk_log(0, 8'h96, 1'b0, 0, 1'b1);

        rlog.delete();
        push(2, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        push(2, 8'h12, 8'h00, 1'b1, 1'b1, 0);
        wait_idle(50);
        chk_log(0, 8'h00, 1'b1, 2, 1'b0);
        chk_log(1, 8'h13, 1'b0, 2, 1'b1);

        rlog.delete();
        push(2, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        push(2, 8'h12, 8'h00, 1'b1, 1'b1, 3);
        wait_idle(50);
        chk_log(0, 8'h00, 1'b1, 2, 1'b0);
        chk_log(1, 8'h13, 1'b0, 2, 1'b1);

        do_reset(2);
        rlog.delete();
        for (int i = 0; i < N; i++) push(i, W'(8'h10 * i), 8'h01, 1'b0, 1'b1, 0);
        push(0, 8'hA0, 8'h05, 1'b0, 1'b1, 0);
        push(1, 8'hB0, 8'h05, 1'b0, 1'b1, 0);
        wait_idle(50);
        chk_log(0, 8'h01, 1'b0, 0, 1'b1);
        chk_log(1, 8'h11, 1'b0, 1, 1'b1);
        chk_log(2, 8'h21, 1'b0, 2, 1'b1);
        chk_log(3, 8'h31, 1'b0, 3, 1'b1);
        chk_log(4, 8'hA5, 1'b0, 0, 1'b1);
        chk_log(5, 8'hB5, 1'b0, 1, 1'b1);
        if (rlog.size() == 6)
            chk("rr_throughput", 32'(rlog[5].cyc - rlog[0].cyc), 5);

        rlog.delete();
        push(1, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
        push(1, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        push(1, 8'h80, 8'h80, 1'b1, 1'b1, 0);
        push(0, 8'h01, 8'h02, 1'b0, 1'b1, 1);
        push(3, 8'h03, 8'h04, 1'b1, 1'b1, 1);
        wait_idle(60);
        chk_log(0, 8'hFE, 1'b1, 1, 1'b0);
        chk_log(1, 8'h01, 1'b0, 1, 1'b0);
        chk_log(2, 8'h00, 1'b1, 1, 1'b1);
        chk_log(3, 8'h08, 1'b0, 3, 1'b1);
        chk_log(4, 8'h03, 1'b0, 0, 1'b1);

        rlog.delete();
        rdy_mode = 1;
        @(posedge clk);
        #2 acc0 = acc_cnt[0];
        for (int i = 0; i < 6; i++) push(0, W'(8'h11 * i), W'(i), 1'b0, 1'b1, 0);
        repeat (8) @(posedge clk);
        #2 chk("bp_accepted", 32'(acc_cnt[0] - acc0), 2);
        rdy_mode = 0;
        wait_idle(60);
        chk("bp_count", 32'(rlog.size()), 6);
        for (int i = 0; i < 6; i++) chk_log(i, W'(8'h12 * i), 1'b0, 0, 1'b1);

        rlog.delete();
        acc0 = acc_cnt[0];
        push(0, 8'h40, 8'h01, 1'b1, 1'b0, 0);
        push(0, 8'h50, 8'h02, 1'b0, 1'b1, 6);
        k = 0;
        while (acc_cnt[0] == acc0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        chk("rst_burst_beat0", 32'(acc_cnt[0] - acc0), 1);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 push(0, 8'h10, 8'h20, 1'b1, 1'b1, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        wait_idle(50);
        chk("rst_count", 32'(rlog.size()), 1);
        chk_log(0, 8'h31, 1'b0, 0, 1'b1);

        rlog.delete();
        rdy_mode = 2;
        nbeats = 0;
        for (int r = 0; r < 60; r++) begin
            int i, len;
            i = $urandom_range(0, N - 1);
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
                push(i, W'($urandom), W'($urandom), 1'($urandom), (b == len - 1),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                nbeats++;
            end
        end
        wait_idle(4000);
        chk("rand_count", 32'(rlog.size()), 32'(nbeats));
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
